// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Brief    : Oversampling UART receiver front end. Synchronises the serial
//            line, runs a baud tick divider, majority-votes three samples
//            around mid-bit and delivers bytes with valid / framing strobes.
//            Optional parity checking: define UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
  parameter int DATA_W      = 8,
  parameter int OS_RATE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rec_en,
  input  logic [15:0]       comp,
  input  logic              uart_rx,
`ifdef UART_RX_PARITY_EN
  input  logic              par_en,
  input  logic              par_odd,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int c_OS_W = $clog2(OS_RATE);
  localparam int c_BC_W = $clog2(DATA_W + 1);
  localparam int c_M    = OS_RATE / 2;

  localparam logic [c_OS_W-1:0] c_OS_S0   = c_OS_W'(c_M - 1);
  localparam logic [c_OS_W-1:0] c_OS_S1   = c_OS_W'(c_M);
  localparam logic [c_OS_W-1:0] c_OS_S2   = c_OS_W'(c_M + 1);
  localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OS_RATE - 1);
  localparam logic [c_OS_W-1:0] c_OS_ONE  = c_OS_W'(1);
  localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(DATA_W);
  localparam logic [c_BC_W-1:0] c_BC_ONE  = c_BC_W'(1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_STOP   = 3'd3;
  localparam logic [2:0] c_ST_BRK    = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = 3'd5;
`endif

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_p;
  logic [15:0]            r_tcnt;
  logic [c_OS_W-1:0]      r_os;
  logic [c_BC_W-1:0]      r_bcnt;
  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic                   r_smp0;
  logic                   r_smp1;
  logic [DATA_W-1:0]      r_shift;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_valid;
  logic                   r_ferr;

  logic                   w_rx_s;
  logic                   w_tick;
  logic                   w_run;
  logic                   w_maj;
  logic                   w_at_s0;
  logic                   w_at_s1;
  logic                   w_at_dec;
  logic                   w_at_end;
  logic                   w_start_det;
  logic                   w_shift_en;
  logic                   w_good;
  logic                   w_bad;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_bit;
  logic                   r_par_used;
  logic                   r_perr;
  logic                   w_par_cap;
  logic                   w_par_bad;
`endif

  assign w_rx_s      = r_sync[SYNC_STAGES-1];
  assign w_tick      = (r_tcnt == comp);
  assign w_run       = rec_en && (r_state != c_ST_IDLE) && (r_state != c_ST_BRK);
  assign w_at_s0     = w_run && w_tick && (r_os == c_OS_S0);
  assign w_at_s1     = w_run && w_tick && (r_os == c_OS_S1);
  assign w_at_dec    = w_run && w_tick && (r_os == c_OS_S2);
  assign w_at_end    = w_run && w_tick && (r_os == c_OS_LAST);
  assign w_start_det = rec_en && (r_state == c_ST_IDLE) && r_rx_p && !w_rx_s;
  // Third vote is the live synchronised line at the deciding tick.
  assign w_maj       = (r_smp0 & r_smp1) | (r_smp0 & w_rx_s) | (r_smp1 & w_rx_s);

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_cap   = 1'b0;
`endif
    case (r_state)
      c_ST_IDLE: begin
        if (w_start_det) w_state_nxt = c_ST_START;
      end
      c_ST_START: begin
        if (w_at_dec && w_maj) w_state_nxt = c_ST_IDLE;
        else if (w_at_end)     w_state_nxt = c_ST_DATA;
      end
      c_ST_DATA: begin
        w_shift_en = w_at_dec;
        if (w_at_end && (r_bcnt == c_BC_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = par_en ? c_ST_PARITY : c_ST_STOP;
`else
          w_state_nxt = c_ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      c_ST_PARITY: begin
        w_par_cap = w_at_dec;
        if (w_at_end) w_state_nxt = c_ST_STOP;
      end
`endif
      c_ST_STOP: begin
        // Decide half a bit early so the next start edge is never missed.
        if (w_at_dec) begin
          if (w_maj) begin
            w_good      = 1'b1;
            w_state_nxt = c_ST_IDLE;
          end else begin
            w_bad       = 1'b1;
            w_state_nxt = c_ST_BRK;
          end
        end
      end
      c_ST_BRK: begin
        if (w_rx_s) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
    if (!rec_en) w_state_nxt = c_ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync <= '1;
      r_rx_p <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
      r_rx_p <= w_rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tcnt <= '0;
    end else if (!rec_en || (r_state == c_ST_IDLE) || w_tick) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_os   <= '0;
      r_smp0 <= 1'b1;
      r_smp1 <= 1'b1;
    end else begin
      if (!w_run) begin
        r_os <= '0;
      end else if (w_tick) begin
        r_os <= (r_os == c_OS_LAST) ? '0 : r_os + c_OS_ONE;
      end
      if (w_at_s0) r_smp0 <= w_rx_s;
      if (w_at_s1) r_smp1 <= w_rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      if (!rec_en || (r_state != c_ST_DATA)) begin
        r_bcnt <= '0;
      end else if (w_shift_en) begin
        r_bcnt <= r_bcnt + c_BC_ONE;
      end
      if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= c_ST_IDLE;
      r_rx_data <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_good;
      r_ferr  <= w_bad;
      if (w_good) r_rx_data <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  // XOR of data plus parity bit is 0 for even, 1 for odd when correct.
  assign w_par_bad = r_par_used & ((^{r_shift, r_par_bit}) ^ par_odd);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_par_bit  <= 1'b0;
      r_par_used <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      if (w_par_cap) r_par_bit <= w_maj;
      if (r_state == c_ST_PARITY)    r_par_used <= 1'b1;
      else if (r_state == c_ST_IDLE) r_par_used <= 1'b0;
      r_perr <= w_good & w_par_bad;
    end
  end

  assign par_err = r_perr;
`endif

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// Testbench for uart_rx_os: directed and random frames against an ideal
// bit-level receiver model (byte delivered iff stop bit is 1).
module tb_uart_rx_os;
  localparam int DATA_W      = 8;
  localparam int OS_RATE     = 16;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              rec_en;
  logic [15:0]       comp;
  logic              uart_rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              busy;
`ifdef UART_RX_PARITY_EN
  logic              par_en;
  logic              par_odd;
  logic              par_err;
  logic              mon_perr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_both  = 0;
  logic [DATA_W-1:0] mon_data = '0;

  always #5 clk = ~clk;

  uart_rx_os #(
    .DATA_W(DATA_W), .OS_RATE(OS_RATE), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rec_en(rec_en),
    .comp(comp),
    .uart_rx(uart_rx),
`ifdef UART_RX_PARITY_EN
    .par_en(par_en),
    .par_odd(par_odd),
    .par_err(par_err),
`endif
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      mon_data = rx_data;
`ifdef UART_RX_PARITY_EN
      mon_perr = par_err;
`endif
    end
    if (frame_err) n_ferr++;
    if (rx_valid && frame_err) n_both++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bclk,
                            input logic has_par, input logic par_b);
    drive(1'b0, bclk);
    for (int i = 0; i < DATA_W; i++) drive(d[i], bclk);
    if (has_par) drive(par_b, bclk);
    drive(stop_b, bclk);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int v0;
    int f0;
    int bclk;
    logic [7:0] d;
    logic [7:0] exp_data;
    logic stop_b;

    rstn = 1'b0; rec_en = 1'b1; comp = 16'd0; uart_rx = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_en = 1'b0; par_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Basic 0x55 frame at 16 clocks per bit.
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b1, 16, 1'b0, 1'b0);
    chk("t1_busy_after_stop", 32'(busy), 32'd0);
    drive(1'b1, 10);
    settle();
    chk("t1_valid_count", 32'(n_valid - v0), 32'd1);
    chk("t1_rx_data", 32'(mon_data), 32'h55);
    chk("t1_ferr_count", 32'(n_ferr - f0), 32'd0);
    exp_data = 8'h55;

    // Short low pulse: false start.
    v0 = n_valid; f0 = n_ferr;
    drive(1'b0, 4);
    drive(1'b1, 1);
    chk("t2_busy_in_start", 32'(busy), 32'd1);
    drive(1'b1, 30);
    settle();
    chk("t2_valid_count", 32'(n_valid - v0), 32'd0);
    chk("t2_ferr_count", 32'(n_ferr - f0), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // Framing error with a held-low line, then a good frame.
    v0 = n_valid; f0 = n_ferr;
    drive(1'b0, 16);
    for (int i = 0; i < DATA_W; i++) drive(d_of(8'hA5, i), 16);
    drive(1'b0, 30);
    #1;
    chk("t3_ferr_once", 32'(n_ferr - f0), 32'd1);
    chk("t3_busy_in_break", 32'(busy), 32'd1);
    drive(1'b0, 10);
    #1;
    chk("t3_no_retrigger", 32'(n_ferr - f0), 32'd1);
    drive(1'b1, 20);
    settle();
    chk("t3_no_valid", 32'(n_valid - v0), 32'd0);
    chk("t3_rx_data_held", 32'(rx_data), 32'(exp_data));
    v0 = n_valid;
    send_frame(8'h3C, 1'b1, 16, 1'b0, 1'b0);
    drive(1'b1, 8);
    settle();
    chk("t3_valid_after", 32'(n_valid - v0), 32'd1);
    chk("t3_rx_data_3c", 32'(mon_data), 32'h3C);
    exp_data = 8'h3C;

    // comp=3: single-sample glitch inside bit 7 is voted out.
    comp = 16'd3; bclk = 64;
    v0 = n_valid;
    drive(1'b0, bclk);
    for (int i = 0; i < 7; i++) drive(d_of(8'hF0, i), bclk);
    drive(1'b1, 34);
    drive(1'b0, 4);
    drive(1'b1, 26);
    drive(1'b1, bclk);
    drive(1'b1, 20);
    settle();
    chk("t4_valid_count", 32'(n_valid - v0), 32'd1);
    chk("t4_rx_data_f0", 32'(mon_data), 32'hF0);
    exp_data = 8'hF0;
    comp = 16'd0;

    // Abort with rec_en during bit 4 of 0x81.
    v0 = n_valid; f0 = n_ferr;
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(d_of(8'h81, i), 16);
    drive(1'b0, 8);
    rec_en = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_abort_idle", 32'(busy), 32'd0);
    drive(1'b0, 7);
    for (int i = 5; i < DATA_W; i++) drive(d_of(8'h81, i), 16);
    drive(1'b1, 26);
    rec_en = 1'b1;
    drive(1'b1, 10);
    settle();
    chk("t5_abort_no_valid", 32'(n_valid - v0), 32'd0);
    chk("t5_abort_no_ferr", 32'(n_ferr - f0), 32'd0);
    chk("t5_abort_data_held", 32'(rx_data), 32'(exp_data));
    send_frame(8'h7E, 1'b1, 16, 1'b0, 1'b0);
    drive(1'b1, 8);
    settle();
    chk("t5_valid_after", 32'(n_valid - v0), 32'd1);
    chk("t5_rx_data_7e", 32'(mon_data), 32'h7E);

    // Reset in the middle of bit 7 of 0x81.
    v0 = n_valid; f0 = n_ferr;
    drive(1'b0, 16);
    for (int i = 0; i < 7; i++) drive(d_of(8'h81, i), 16);
    drive(1'b1, 8);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_rst_rx_data", 32'(rx_data), 32'd0);
    chk("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("t6_rst_frame_err", 32'(frame_err), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    drive(1'b1, 40);
    settle();
    chk("t6_no_valid", 32'(n_valid - v0), 32'd0);
    chk("t6_no_ferr", 32'(n_ferr - f0), 32'd0);
    exp_data = 8'h00;

    // Random frames, random baud divider, occasional bad stop bit.
    for (int k = 0; k < 10; k++) begin
      comp   = 16'($urandom_range(0, 2));
      bclk   = (int'(comp) + 1) * OS_RATE;
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      v0 = n_valid; f0 = n_ferr;
      send_frame(d, stop_b, bclk, 1'b0, 1'b0);
      drive(1'b1, $urandom_range(4, 20));
      settle();
      if (stop_b) exp_data = d;
      chk("rand_valid_count", 32'(n_valid - v0), stop_b ? 32'd1 : 32'd0);
      chk("rand_ferr_count", 32'(n_ferr - f0), stop_b ? 32'd0 : 32'd1);
      chk("rand_rx_data", 32'(rx_data), 32'(exp_data));
    end
    comp = 16'd0;

`ifdef UART_RX_PARITY_EN
    par_en = 1'b1; par_odd = 1'b0;
    v0 = n_valid;
    send_frame(8'h01, 1'b1, 16, 1'b1, 1'b1);
    drive(1'b1, 8);
    settle();
    chk("par_even_ok_valid", 32'(n_valid - v0), 32'd1);
    chk("par_even_ok_perr", 32'(mon_perr), 32'd0);
    v0 = n_valid;
    send_frame(8'h01, 1'b1, 16, 1'b1, 1'b0);
    drive(1'b1, 8);
    settle();
    chk("par_even_bad_valid", 32'(n_valid - v0), 32'd1);
    chk("par_even_bad_perr", 32'(mon_perr), 32'd1);
    chk("par_even_bad_data", 32'(mon_data), 32'h01);
    par_odd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic pb;
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      v0 = n_valid;
      send_frame(d, 1'b1, 16, 1'b1, pb);
      drive(1'b1, 8);
      settle();
      chk("par_odd_valid", 32'(n_valid - v0), 32'd1);
      chk("par_odd_perr", 32'(mon_perr),
          ((($countones(d) + int'(pb)) % 2) == 1) ? 32'd0 : 32'd1);
    end
    par_en = 1'b0; par_odd = 1'b0;
`endif

    chk("never_both_strobes", 32'(n_both), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic d_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
`default_nettype wire
